// File: rtl/bfm_apb_slave_mem.sv
// APB3 completer BFM: word-addressed RAM with programmable wait states,
// PSLVERR injection on out-of-range addresses and a sticky protocol-violation flag.
module bfm_apb_slave_mem #(
    parameter int unsigned AWIDTH    = 10,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [3:0]  WAIT_CFG,
    input  logic        ERR_EN,
    output logic        PROT_ERR
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;
    logic                lat_write;
    logic                lat_oor;
    logic                lat_err;

    // Declaration initialiser is simulation/FPGA power-up content only; reset never touches it.
    logic [31:0]         mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    logic                setup;
    logic                setup_oor;
    logic [AWIDTH-1:0]   setup_idx;
    logic [AWIDTH-1:0]   lat_idx;
    logic                changed;
    logic                mem_we;

    always_comb begin
        setup     = PSEL && !PENABLE;
        setup_oor = |PADDR[31:AWIDTH+2];
        setup_idx = PADDR[AWIDTH+1:2];
        lat_idx   = lat_addr[AWIDTH+1:2];
        changed   = (PADDR != lat_addr) || (PWRITE != lat_write) || (PWDATA != lat_wdata);
        // Commit at the completion edge; a dropped PSEL or reset in DONE suppresses it.
        mem_we    = PRESETN && (state == DONE) && PSEL && lat_write && !lat_oor;
    end

    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state     <= IDLE;
            cnt       <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            PROT_ERR  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_oor   <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (setup) begin
                        lat_addr  <= PADDR;
                        lat_wdata <= PWDATA;
                        lat_write <= PWRITE;
                        lat_oor   <= setup_oor;
                        lat_err   <= ERR_EN;
                        cnt       <= WAIT_CFG;
                        if (WAIT_CFG == 4'd0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= setup_oor && ERR_EN;
                            PRDATA  <= (!PWRITE && !setup_oor) ? mem[setup_idx] : '0;
                            state   <= DONE;
                        end else begin
                            state   <= ACCESS;
                        end
                    end else if (PSEL && PENABLE) begin
                        PROT_ERR <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (!PSEL) begin
                        PROT_ERR <= 1'b1;
                        PREADY   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (!PENABLE || changed) begin
                            PROT_ERR <= 1'b1;
                        end
                        cnt <= cnt - 4'd1;
                        // Raising PREADY at cnt==1 yields exactly WAIT_CFG wait cycles.
                        if (cnt == 4'd1) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= lat_oor && lat_err;
                            PRDATA  <= (!lat_write && !lat_oor) ? mem[lat_idx] : '0;
                            state   <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (!PSEL || !PENABLE || changed) begin
                        PROT_ERR <= 1'b1;
                    end
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    state   <= IDLE;
                end

                default: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Self-checking bench for bfm_apb_slave_mem: scoreboarded APB transfers plus
// hand-driven protocol-violation and reset-abort scenarios.
module tb_bfm_apb_slave_mem;

    logic        PCLK;
    logic        PRESETN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  WAIT_CFG;
    logic        ERR_EN;
    logic        PROT_ERR;

    bfm_apb_slave_mem #(.AWIDTH(10), .INIT_ZERO(1'b1)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .WAIT_CFG(WAIT_CFG),
        .ERR_EN(ERR_EN), .PROT_ERR(PROT_ERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
        bit          quiet;
        bit          timed_out;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    bit [31:0] model [1024];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: updates the memory image and returns the expected response.
    function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] w,
                                     input logic e);
        exp_t r;
        bit oor;
        oor = (addr[31:12] != 20'h0);
        if (wr && !oor) model[addr[11:2]] = wdata;
        r.rd    = !wr;
        r.data  = (!wr && !oor) ? model[addr[11:2]] : 32'h0;
        r.err   = oor && e;
        r.waits = int'(w);
        return r;
    endfunction

    task automatic idle();
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge PCLK);
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETN = 1'b1;
    endtask

    // Drives one APB transfer, pushing the expectation then the observation.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] w, input logic e);
        obs_t o;
        exp_q.push_back(predict(wr, addr, wdata, w, e));
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        WAIT_CFG = w; ERR_EN = e;
        @(negedge PCLK);
        PENABLE = 1'b1;
        WAIT_CFG = ~w; ERR_EN = ~e;
        o.waits = 0; o.quiet = 1'b1; o.timed_out = 1'b1; o.data = '0; o.err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (PREADY === 1'b1) begin
                o.data = PRDATA; o.err = PSLVERR; o.timed_out = 1'b0;
                break;
            end
            if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) o.quiet = 1'b0;
            o.waits++;
            @(negedge PCLK);
        end
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; WAIT_CFG = '0; ERR_EN = 1'b0;
        repeat (3) @(negedge PCLK);
        vectors++;
        if (PREADY !== 1'b0) begin miscompares++; $display("FAIL reset_pready: got %b want 0", PREADY); end
        vectors++;
        if (PSLVERR !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
        vectors++;
        if (PRDATA !== 32'h0) begin miscompares++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
        vectors++;
        if (PROT_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_prot_err: got %b want 0", PROT_ERR); end
        PRESETN = 1'b1;
    endtask

    task automatic test_zero_wait();
        exp_t e; obs_t o;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 4'd0, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o.timed_out || o.waits != e.waits || o.err !== e.err || !o.quiet || (e.rd && o.data !== e.data)) begin
                miscompares++;
                $display("FAIL zero_wait: got data=%h err=%b waits=%0d quiet=%b timeout=%b, want data=%h err=%b waits=%0d",
                         o.data, o.err, o.waits, o.quiet, o.timed_out, e.data, e.err, e.waits);
            end
        end
        vectors++;
        if (PROT_ERR !== 1'b0) begin miscompares++; $display("FAIL zero_wait_prot_err: got %b want 0", PROT_ERR); end
    endtask

    task automatic test_wait_states();
        exp_t e; obs_t o;
        logic [3:0] ws [3] = '{4'd1, 4'd7, 4'd15};
        xfer(1'b1, 32'h04, 32'h0404A5A5, 4'd0, 1'b0);
        idle();
        xfer(1'b0, 32'h04, 32'h0, 4'd3, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'h10, 32'h0, ws[i], 1'b0);
            idle();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o.timed_out || o.waits != e.waits || o.err !== e.err || !o.quiet || (e.rd && o.data !== e.data)) begin
                miscompares++;
                $display("FAIL wait_states: got data=%h err=%b waits=%0d quiet=%b timeout=%b, want data=%h err=%b waits=%0d",
                         o.data, o.err, o.waits, o.quiet, o.timed_out, e.data, e.err, e.waits);
            end
        end
    endtask

    task automatic test_oor();
        exp_t e; obs_t o;
        xfer(1'b1, 32'h0, 32'h11111111, 4'd0, 1'b1);
        xfer(1'b1, 32'h1000, 32'h5, 4'd0, 1'b1);
        xfer(1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        xfer(1'b0, 32'h1000, 32'h0, 4'd2, 1'b1);
        xfer(1'b1, 32'h1000, 32'h5, 4'd2, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 4'd1, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o.timed_out || o.waits != e.waits || o.err !== e.err || !o.quiet || (e.rd && o.data !== e.data)) begin
                miscompares++;
                $display("FAIL oor: got data=%h err=%b waits=%0d quiet=%b timeout=%b, want data=%h err=%b waits=%0d",
                         o.data, o.err, o.waits, o.quiet, o.timed_out, e.data, e.err, e.waits);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        xfer(1'b1, 32'h0, 32'hA0A0A0A0, 4'd1, 1'b0);
        xfer(1'b1, 32'h4, 32'hB1B1B1B1, 4'd1, 1'b0);
        xfer(1'b1, 32'h8, 32'hC2C2C2C2, 4'd1, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 4'd1, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 4'd1, 1'b0);
        xfer(1'b0, 32'h8, 32'h0, 4'd1, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o.timed_out || o.waits != e.waits || o.err !== e.err || !o.quiet || (e.rd && o.data !== e.data)) begin
                miscompares++;
                $display("FAIL back_to_back: got data=%h err=%b waits=%0d quiet=%b timeout=%b, want data=%h err=%b waits=%0d",
                         o.data, o.err, o.waits, o.quiet, o.timed_out, e.data, e.err, e.waits);
            end
        end
        vectors++;
        if (PROT_ERR !== 1'b0) begin miscompares++; $display("FAIL b2b_prot_err: got %b want 0", PROT_ERR); end
    endtask

    task automatic test_prot_abort();
        exp_t e; obs_t o;
        bit saw_ready = 1'b0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h55; WAIT_CFG = 4'd5; ERR_EN = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (PREADY === 1'b1) saw_ready = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (PREADY === 1'b1) saw_ready = 1'b1;
            @(negedge PCLK);
        end
        vectors++;
        if (saw_ready) begin miscompares++; $display("FAIL abort_pready: got 1 want 0"); end
        vectors++;
        if (PROT_ERR !== 1'b1) begin miscompares++; $display("FAIL abort_prot_err: got %b want 1", PROT_ERR); end
        xfer(1'b0, 32'h30, 32'h0, 4'd0, 1'b0);
        idle();
        e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
        if (o.timed_out || o.data !== e.data || o.err !== e.err) begin
            miscompares++;
            $display("FAIL abort_ram: got data=%h err=%b timeout=%b, want data=%h err=%b", o.data, o.err, o.timed_out, e.data, e.err);
        end
        vectors++;
        if (PROT_ERR !== 1'b1) begin miscompares++; $display("FAIL prot_err_sticky: got %b want 1", PROT_ERR); end
        pulse_reset();
        @(negedge PCLK);
        vectors++;
        if (PROT_ERR !== 1'b0) begin miscompares++; $display("FAIL prot_err_cleared: got %b want 0", PROT_ERR); end
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h0;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        vectors++;
        if (PREADY !== 1'b0) begin miscompares++; $display("FAIL no_setup_pready: got %b want 0", PREADY); end
        @(negedge PCLK);
        vectors++;
        if (PROT_ERR !== 1'b1) begin miscompares++; $display("FAIL no_setup_prot_err: got %b want 1", PROT_ERR); end
        pulse_reset();
    endtask

    task automatic test_reset_mid();
        exp_t e; obs_t o;
        xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'd0, 1'b0);
        idle();
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h40; PWDATA = 32'h0BADBAD0; WAIT_CFG = 4'd4;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETN = 1'b0;
        @(negedge PCLK);
        vectors++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0 || PROT_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got pready=%b pslverr=%b prdata=%h prot_err=%b want all 0",
                     PREADY, PSLVERR, PRDATA, PROT_ERR);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETN = 1'b1;
        xfer(1'b0, 32'h40, 32'h0, 4'd2, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o.timed_out || o.waits != e.waits || o.err !== e.err || !o.quiet || (e.rd && o.data !== e.data)) begin
                miscompares++;
                $display("FAIL reset_mid_ram: got data=%h err=%b waits=%0d quiet=%b timeout=%b, want data=%h err=%b waits=%0d",
                         o.data, o.err, o.waits, o.quiet, o.timed_out, e.data, e.err, e.waits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_oor();
        test_back_to_back();
        test_prot_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
